// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch mode controller: state encoding,
// digit indices, clamp limits and small helpers.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPause  = 2'd2,
    StAdjust = 2'd3
  } state_e;

  localparam logic [1:0] SEC_R = 2'd0;
  localparam logic [1:0] SEC_L = 2'd1;
  localparam logic [1:0] MIN_R = 2'd2;
  localparam logic [1:0] MIN_L = 2'd3;

  localparam int unsigned TENS_MAX_DEF  = 5;
  localparam int unsigned UNITS_MAX_DEF = 9;

  // Tens digits (sec_l, min_l) saturate at tens_max, units digits at units_max.
  function automatic logic [4:0] clamp_digit(logic [1:0] sel, logic [3:0] num,
                                             int unsigned tens_max, int unsigned units_max);
    int unsigned lim;
    lim = (sel == SEC_L || sel == MIN_L) ? tens_max : units_max;
    return (32'(num) > lim) ? 5'(lim) : {1'b0, num};
  endfunction

  function automatic logic [3:0] digit_onehot(logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the debouncers/clock divider, the mode controller and
// the digit counter/display.
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_adj;
  logic       tick_blink;
  logic       btn_reset;
  logic       btn_pause;
  logic       sw_adj;
  logic [1:0] sw_sel;
  logic [3:0] sw_num;
  logic       count_en;
  logic       clr;
  logic       adj_we;
  logic [2:0] adj_sel;
  logic [4:0] adj_val;
  logic [3:0] blank_mask;
  logic [1:0] state;

  modport master (
    output tick_1hz, tick_adj, tick_blink, btn_reset, btn_pause, sw_adj, sw_sel, sw_num,
    input  count_en, clr, adj_we, adj_sel, adj_val, blank_mask, state
  );

  modport slave (
    input  tick_1hz, tick_adj, tick_blink, btn_reset, btn_pause, sw_adj, sw_sel, sw_num,
    output count_en, clr, adj_we, adj_sel, adj_val, blank_mask, state
  );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge pulse generator for a debounced button level. The first clock
// after reset only loads the history, so a button held through reset is silent.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic hist_q, hist_d;
  logic armed_q, armed_d;

  assign hist_d  = level_i;
  assign armed_d = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      armed_q <= armed_d;
    end
  end

  assign pulse_o = armed_q & level_i & ~hist_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: IDLE/RUN/PAUSE/ADJUST FSM plus counter strobes.
// Define STOPWATCH_BLINK_EN to enable the adjust-mode digit blink mask.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TENS_MAX  = TENS_MAX_DEF,
  parameter int unsigned UNITS_MAX = UNITS_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);

  logic   rst_edge, pause_edge;
  state_e state_q, state_d;

  logic       count_en_q, count_en_d;
  logic       clr_q, clr_d;
  logic       adj_we_q, adj_we_d;
  logic [2:0] adj_sel_q, adj_sel_d;
  logic [4:0] adj_val_q, adj_val_d;
  logic [3:0] blank_mask_q, blank_mask_d;

  edge_detect u_rst_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (bus.btn_reset),
    .pulse_o (rst_edge)
  );

  edge_detect u_pause_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (bus.btn_pause),
    .pulse_o (pause_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Priority: reset edge, then the adjust switch, then the pause edge.
  always_comb begin
    state_d = state_q;
    if (rst_edge) begin
      state_d = bus.sw_adj ? StAdjust : StIdle;
    end else if (state_q != StAdjust && bus.sw_adj) begin
      state_d = StAdjust;
    end else if (state_q == StAdjust && !bus.sw_adj) begin
      state_d = StPause;
    end else if (pause_edge) begin
      unique case (state_q)
        StIdle:   state_d = StRun;
        StRun:    state_d = StPause;
        StPause:  state_d = StRun;
        StAdjust: state_d = StAdjust;
      endcase
    end
  end

`ifdef STOPWATCH_BLINK_EN
  logic phase_q, phase_d;

  // Phase restarts on every ADJUST entry, including a reset edge taken inside ADJUST.
  always_comb begin
    phase_d = phase_q;
    if (state_d == StAdjust && (state_q != StAdjust || rst_edge)) begin
      phase_d = 1'b0;
    end else if (state_q == StAdjust && state_d == StAdjust && bus.tick_blink) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= 1'b0;
    else        phase_q <= phase_d;
  end

  assign blank_mask_d = (state_d == StAdjust && phase_d) ? digit_onehot(bus.sw_sel) : 4'b0000;
`else
  assign blank_mask_d = 4'b0000;
`endif

  // Strobes use the current state; adjust outputs track the state being entered
  // so they line up with the registered state output.
  always_comb begin
    count_en_d = bus.tick_1hz & (state_q == StRun);
    adj_we_d   = bus.tick_adj & (state_q == StAdjust);
    clr_d      = rst_edge;
    adj_sel_d  = {state_d == StAdjust, bus.sw_sel};
    adj_val_d  = (state_d == StAdjust) ? clamp_digit(bus.sw_sel, bus.sw_num, TENS_MAX, UNITS_MAX)
                                       : 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_en_q   <= 1'b0;
      clr_q        <= 1'b0;
      adj_we_q     <= 1'b0;
      adj_sel_q    <= 3'd0;
      adj_val_q    <= 5'd0;
      blank_mask_q <= 4'd0;
    end else begin
      count_en_q   <= count_en_d;
      clr_q        <= clr_d;
      adj_we_q     <= adj_we_d;
      adj_sel_q    <= adj_sel_d;
      adj_val_q    <= adj_val_d;
      blank_mask_q <= blank_mask_d;
    end
  end

  assign bus.count_en   = count_en_q;
  assign bus.clr        = clr_q;
  assign bus.adj_we     = adj_we_q;
  assign bus.adj_sel    = adj_sel_q;
  assign bus.adj_val    = adj_val_q;
  assign bus.blank_mask = blank_mask_q;
  assign bus.state      = state_q;

endmodule
